// File: rtl/fifo_consumer.sv
// fifo_consumer: read-side engine for the async FIFO, consumer clock domain.
// Drains a burst of words, paces reads with a programmable idle gap,
// re-presents each word with a valid strobe and keeps word/error counters.
// Optional build macro: CONSUMER_CHECK_EN enables the fill-pattern checker
// feeding ERR_CNT; when undefined ERR_CNT is tied to zero.
module fifo_consumer #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 1024,
   parameter int CNT_W      = $clog2(MAX_BURST + 1)
) (
   input  logic                  CON_CLK,
   input  logic                  RST_n,
   input  logic                  START,
   input  logic [CNT_W-1:0]      BURST_LEN,
   input  logic [3:0]            RD_IDLE,
   input  logic                  EMPTY,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   output logic                  R_EN,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   output logic                  DATA_VALID,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [CNT_W-1:0]      WORD_CNT,
   output logic [CNT_W-1:0]      ERR_CNT
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CAPTURE,
      S_GAP,
      S_FIN
   } state_t;

   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BURST);

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_armed;
   logic [CNT_W-1:0]      r_len;
   logic [3:0]            r_idle;
   logic [3:0]            r_gap_cnt;
   logic [CNT_W-1:0]      r_word_cnt;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_data_valid;

   logic [CNT_W-1:0]      w_len_clamped;
   logic [CNT_W-1:0]      w_cnt_inc;
   logic                  w_start_acc;

   assign w_len_clamped = (BURST_LEN > MAX_LEN) ? MAX_LEN : BURST_LEN;
   assign w_cnt_inc     = r_word_cnt + CNT_W'(1);
   // r_armed masks a START that coincides with reset release
   assign w_start_acc   = START & r_armed & (r_state == S_IDLE);

   // Goes high one clock after reset release; START is honoured only then
   always_ff @(posedge CON_CLK or negedge RST_n) begin
      if (!RST_n) r_armed <= 1'b0;
      else        r_armed <= 1'b1;
   end

   // State register
   always_ff @(posedge CON_CLK or negedge RST_n) begin
      if (!RST_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state and state-decoded outputs; R_EN never fires while EMPTY
   always_comb begin
      w_state_next = r_state;
      R_EN         = 1'b0;
      BUSY         = (r_state != S_IDLE);
      DONE         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_acc)
               w_state_next = (w_len_clamped == '0) ? S_FIN : S_READ;
         end
         S_READ: begin
            R_EN = ~EMPTY;
            if (!EMPTY) w_state_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (w_cnt_inc == r_len)  w_state_next = S_FIN;
            else if (r_idle != 4'd0) w_state_next = S_GAP;
            else                     w_state_next = S_READ;
         end
         S_GAP: begin
            if (r_gap_cnt <= 4'd1) w_state_next = S_READ;
         end
         S_FIN: begin
            DONE         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Burst parameters, capture path, word counter and gap countdown
   always_ff @(posedge CON_CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_len        <= '0;
         r_idle       <= '0;
         r_gap_cnt    <= '0;
         r_word_cnt   <= '0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         if (w_start_acc) begin
            r_len      <= w_len_clamped;
            r_idle     <= RD_IDLE;
            r_word_cnt <= '0;
         end
         if (r_state == S_CAPTURE) begin
            r_data_out   <= DATA_IN;
            r_data_valid <= 1'b1;
            r_word_cnt   <= w_cnt_inc;
            r_gap_cnt    <= r_idle;
         end else if (r_state == S_GAP) begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
         end
      end
   end

`ifdef CONSUMER_CHECK_EN
   logic [CNT_W-1:0]      r_err_cnt;
   logic [DATA_WIDTH-1:0] w_expected;

   // Capture index i expects (i+1) mod 2^DATA_WIDTH, the producer fill pattern
   assign w_expected = DATA_WIDTH'(w_cnt_inc);

   // Saturating mismatch counter, cleared on an accepted START
   always_ff @(posedge CON_CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_err_cnt <= '0;
      end else if (w_start_acc) begin
         r_err_cnt <= '0;
      end else if ((r_state == S_CAPTURE) && (DATA_IN != w_expected) &&
                   (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign ERR_CNT = r_err_cnt;
`else
   assign ERR_CNT = '0;
`endif

   assign DATA_OUT   = r_data_out;
   assign DATA_VALID = r_data_valid;
   assign WORD_CNT   = r_word_cnt;

endmodule

// File: tb/tb_fifo_consumer.sv
// tb_fifo_consumer: directed bench for fifo_consumer with a simple FIFO model.
// Inputs change 1 ns after the rising edge; the monitor samples on the falling edge.
module tb_fifo_consumer;

   localparam int DW    = 8;
   localparam int CNT_W = 11;

   logic             CON_CLK;
   logic             RST_n;
   logic             START;
   logic [CNT_W-1:0] BURST_LEN;
   logic [3:0]       RD_IDLE;
   logic             EMPTY;
   logic [DW-1:0]    DATA_IN;
   logic             R_EN;
   logic [DW-1:0]    DATA_OUT;
   logic             DATA_VALID;
   logic             BUSY;
   logic             DONE;
   logic [CNT_W-1:0] WORD_CNT;
   logic [CNT_W-1:0] ERR_CNT;

   int checks   = 0;
   int failures = 0;

   // FIFO model storage
   logic [DW-1:0] mem [0:4095];
   int wr_ptr = 0;
   int rd_ptr = 0;

   // Monitor state
   int cyc          = 0;
   int ren_total    = 0;
   int dv_total     = 0;
   int done_total   = 0;
   int b2b_err      = 0;
   int last_ren_cyc = 0;
   int done_cyc     = 0;
   logic prev_ren   = 1'b0;
   int ren_cyc [0:4095];
   logic [DW-1:0] dv_data [0:4095];

   fifo_consumer dut (
      .CON_CLK   (CON_CLK),
      .RST_n     (RST_n),
      .START     (START),
      .BURST_LEN (BURST_LEN),
      .RD_IDLE   (RD_IDLE),
      .EMPTY     (EMPTY),
      .DATA_IN   (DATA_IN),
      .R_EN      (R_EN),
      .DATA_OUT  (DATA_OUT),
      .DATA_VALID(DATA_VALID),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .WORD_CNT  (WORD_CNT),
      .ERR_CNT   (ERR_CNT)
   );

   initial begin
      CON_CLK = 1'b0;
      forever #5 CON_CLK = ~CON_CLK;
   end

   assign EMPTY = (wr_ptr == rd_ptr);

   // FIFO read port: data appears the cycle after R_EN
   initial DATA_IN = '0;
   always @(posedge CON_CLK) begin
      if (R_EN) begin
         DATA_IN <= mem[rd_ptr];
         rd_ptr  <= rd_ptr + 1;
      end
   end

   // Monitor: read pulses, captured words, DONE pulses
   always @(negedge CON_CLK) begin
      cyc = cyc + 1;
      if (R_EN) begin
         if (prev_ren) b2b_err = b2b_err + 1;
         ren_cyc[ren_total] = cyc;
         ren_total    = ren_total + 1;
         last_ren_cyc = cyc;
      end
      prev_ren = R_EN;
      if (DATA_VALID) begin
         dv_data[dv_total] = DATA_OUT;
         dv_total = dv_total + 1;
      end
      if (DONE) begin
         done_total = done_total + 1;
         done_cyc   = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CON_CLK);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic start_burst(input int len, input int idle);
      BURST_LEN = CNT_W'(len);
      RD_IDLE   = 4'(idle);
      START     = 1'b1;
      tick();
      START     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int found;
      found = 0;
      for (int i = 0; i < budget; i++) begin
         if (DONE) begin
            found = 1;
            break;
         end
         tick();
      end
      check(tag, found, 1);
   endtask

   initial begin
      int r0;
      int d0;
      int dn0;
      int ok;
      RST_n     = 1'b0;
      START     = 1'b0;
      BURST_LEN = '0;
      RD_IDLE   = '0;

      // Reset values
      #50;
      check("rst_ren",   R_EN, 0);
      check("rst_busy",  BUSY, 0);
      check("rst_done",  DONE, 0);
      check("rst_dv",    DATA_VALID, 0);
      check("rst_dout",  DATA_OUT, 0);
      check("rst_wcnt",  WORD_CNT, 0);
      check("rst_ecnt",  ERR_CNT, 0);

      // START in the cycle of reset release is ignored
      #50;
      RST_n     = 1'b1;
      BURST_LEN = 11'd3;
      START     = 1'b1;
      tick();
      START = 1'b0;
      #2;
      check("start_at_release_busy", BUSY, 0);
      tick();

      // Burst of 8, no gap
      for (int i = 1; i <= 8; i++) push(DW'(i));
      r0 = ren_total; d0 = dv_total; dn0 = done_total;
      start_burst(8, 0);
      wait_done("b8_done_seen", 100);
      tick();
      check("b8_ren_count", ren_total - r0, 8);
      check("b8_no_b2b", b2b_err, 0);
      check("b8_dv_count", dv_total - d0, 8);
      for (int i = 0; i < 8; i++)
         check($sformatf("b8_data%0d", i), dv_data[d0 + i], 32'(i + 1));
      check("b8_done_after_capture", done_cyc - last_ren_cyc, 2);
      check("b8_done_pulses", done_total - dn0, 1);
      check("b8_done_low", DONE, 0);
      check("b8_busy_low", BUSY, 0);
      check("b8_wcnt", WORD_CNT, 8);
      check("b8_ecnt", ERR_CNT, 0);

      // Burst of 4 with 3 idle cycles: R_EN spacing of 5
      for (int i = 1; i <= 4; i++) push(DW'(i));
      r0 = ren_total;
      start_burst(4, 3);
      wait_done("gap_done_seen", 100);
      tick();
      check("gap_ren_count", ren_total - r0, 4);
      for (int i = 1; i < 4; i++)
         check($sformatf("gap_spacing%0d", i), ren_cyc[r0 + i] - ren_cyc[r0 + i - 1], 5);
      check("gap_wcnt", WORD_CNT, 4);

      // FIFO empty for 20 cycles, then one word arrives
      r0 = ren_total;
      start_burst(1, 0);
      repeat (20) tick();
      check("empty_no_ren", ren_total - r0, 0);
      check("empty_busy", BUSY, 1);
      push(8'h01);
      #1;
      check("empty_ren_on_fall", R_EN, 1);
      wait_done("empty_done_seen", 20);
      check("empty_wcnt", WORD_CNT, 1);
      tick();
      check("empty_ren_count", ren_total - r0, 1);

      // Zero-length burst
      r0 = ren_total;
      start_burst(0, 0);
      check("len0_done_next", DONE, 1);
      tick();
      check("len0_no_ren", ren_total - r0, 0);
      check("len0_wcnt", WORD_CNT, 0);

      // Oversize burst clamps to 1024
      for (int i = 1; i <= 1024; i++) push(DW'(i));
      start_burst(2000, 0);
      wait_done("clamp_done_seen", 2200);
      check("clamp_wcnt", WORD_CNT, 1024);
      check("clamp_ecnt", ERR_CNT, 0);
      tick();
      check("clamp_fifo_drained", EMPTY, 1);

      // Reset mid-burst after 3 of 10 words
      for (int i = 1; i <= 10; i++) push(DW'(i));
      d0 = dv_total;
      start_burst(10, 0);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         if ((dv_total - d0) >= 3 && R_EN) begin
            ok = 1;
            break;
         end
         tick();
      end
      check("midrst_reached", ok, 1);
      RST_n = 1'b0;
      #1;
      check("midrst_ren", R_EN, 0);
      check("midrst_busy", BUSY, 0);
      check("midrst_dout", DATA_OUT, 0);
      check("midrst_dv", DATA_VALID, 0);
      check("midrst_wcnt", WORD_CNT, 0);
      r0 = ren_total;
      repeat (3) tick();
      RST_n = 1'b1;
      repeat (3) tick();
      check("midrst_no_ren_after", ren_total - r0, 0);
      check("midrst_idle", BUSY, 0);
      wr_ptr = rd_ptr;
      push(8'h01);
      push(8'h02);
      start_burst(2, 0);
      wait_done("postrst_done_seen", 50);
      check("postrst_wcnt", WORD_CNT, 2);

      // Pattern check: one corrupted word
      tick();
      push(8'h01); push(8'h02); push(8'hFF); push(8'h04);
      start_burst(4, 0);
      wait_done("pat_done_seen", 50);
      check("pat_wcnt", WORD_CNT, 4);
`ifdef CONSUMER_CHECK_EN
      check("pat_ecnt", ERR_CNT, 1);
`else
      check("pat_ecnt", ERR_CNT, 0);
`endif
      tick();
      check("pat_hold_wcnt", WORD_CNT, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
